// File: rtl/sdram_arbiter_pkg.sv
// Shared SDRAM bus definitions: command codes, field widths and burst defaults
// used by the arbiter, the controller and its clients.
package sdram_arbiter_pkg;

  localparam int CMD_W  = 2;
  localparam int ADDR_W = 22;
  localparam int DATA_W = 32;
  localparam int BUS_W  = CMD_W + ADDR_W + DATA_W;

  localparam logic [CMD_W-1:0] CMD_NOP   = 2'd0;
  localparam logic [CMD_W-1:0] CMD_READ  = 2'd1;
  localparam logic [CMD_W-1:0] CMD_WRITE = 2'd2;

  localparam int DEF_READ_BURST  = 8;
  localparam int DEF_WRITE_BURST = 1;
  localparam int DEF_TIMEOUT     = 1024;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sdram_bus_t;

  typedef enum logic [1:0] {
    SRC_MI = 2'd0,
    SRC_PR = 2'd1,
    SRC_FR = 2'd2
  } src_e;

  // Code 3 is reserved and behaves as NOP.
  function automatic logic cmd_is_active(input logic [CMD_W-1:0] cmd);
    return (cmd == CMD_READ) || (cmd == CMD_WRITE);
  endfunction

endpackage

// File: rtl/sdram_txn_tracker.sv
// Outstanding-transaction bookkeeping: beat down-counter, stall timer and
// routing of controller strobes back to the client that issued the command.
module sdram_txn_tracker
  import sdram_arbiter_pkg::*;
#(
  parameter int READ_BURST_LENGTH = DEF_READ_BURST,
  parameter int WRITE_BURST       = DEF_WRITE_BURST,
  parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic accept,
  input  logic accept_read,
  input  src_e accept_src,
  input  logic data_read_valid,
  input  logic data_write_done,
  output logic free,
  output logic fr_read_valid,
  output logic pr_read_valid,
  output logic mi_write_done,
  output logic pr_write_done,
  output logic timeout
);

  localparam int MAX_BURST = (READ_BURST_LENGTH > WRITE_BURST) ? READ_BURST_LENGTH : WRITE_BURST;
  localparam int CNT_W     = $clog2(MAX_BURST + 1);
  localparam int TMR_W     = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] READ_LEN   = CNT_W'(READ_BURST_LENGTH);
  localparam logic [CNT_W-1:0] WRITE_LEN  = CNT_W'(WRITE_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [TMR_W-1:0] tmr;
  logic             txn_read;
  src_e             txn_src;
  logic             busy;
  logic             strobe_match;
  logic             any_strobe;

  assign busy         = (cnt != '0);
  assign any_strobe   = data_read_valid || data_write_done;
  assign strobe_match = busy && (txn_read ? data_read_valid : data_write_done);

  // The final beat of the previous transaction frees the bus in the same cycle.
  assign free    = !busy || ((cnt == CNT_ONE) && strobe_match);
  assign timeout = busy && (tmr == '0) && !any_strobe;

  assign fr_read_valid = strobe_match &&  txn_read && (txn_src == SRC_FR);
  assign pr_read_valid = strobe_match &&  txn_read && (txn_src == SRC_PR);
  assign mi_write_done = strobe_match && !txn_read && (txn_src == SRC_MI);
  assign pr_write_done = strobe_match && !txn_read && (txn_src == SRC_PR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      tmr      <= '0;
      txn_read <= 1'b0;
      txn_src  <= SRC_MI;
    end else begin
      if (accept) begin
        cnt      <= accept_read ? READ_LEN : WRITE_LEN;
        txn_read <= accept_read;
        txn_src  <= accept_src;
      end else if (timeout) begin
        cnt <= '0;
      end else if (strobe_match) begin
        cnt <= cnt - CNT_ONE;
      end

      if (accept || any_strobe) begin
        tmr <= TMR_RELOAD;
      end else if (busy && (tmr != '0)) begin
        tmr <= tmr - TMR_ONE;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM bus arbiter between the memory initializer, the processor and the
// frame reader, with zero-latency forwarding of the owner's command.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_INIT   | initializer owns the bus until i_Init_Done and bus idle
// ST_PR_OWN | processor owns the bus
// ST_SWITCH | one dead cycle, no grant, NOP driven, then the other owner
// ST_FR_OWN | frame reader owns the bus
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int READ_BURST_LENGTH = DEF_READ_BURST,
  parameter int WRITE_BURST       = DEF_WRITE_BURST,
  parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Init_Done,
  input  logic [BUS_W-1:0] i_MI_Bus,
  input  logic             i_FR_Request,
  input  logic [23:0]      i_FR_Bus,
  input  logic [BUS_W-1:0] i_PR_Bus,
  input  logic             i_Data_Read_Valid,
  input  logic             i_Data_Write_Done,
  output logic [BUS_W-1:0] o_Bus,
  output logic             o_FR_Grant,
  output logic             o_PR_Grant,
  output logic             o_Cmd_Accept,
  output logic             o_FR_Read_Valid,
  output logic             o_PR_Read_Valid,
  output logic             o_MI_Write_Done,
  output logic             o_PR_Write_Done,
  output logic             o_Timeout
);

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_PR_OWN = 2'd1;
  localparam logic [1:0] ST_SWITCH = 2'd2;
  localparam logic [1:0] ST_FR_OWN = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              to_fr;
  logic              to_fr_nxt;

  sdram_bus_t        mi_bus;
  sdram_bus_t        pr_bus;
  sdram_bus_t        fr_bus;
  sdram_bus_t        owner_bus;
  sdram_bus_t        out_bus;
  src_e              owner_src;
  logic              owner_live;
  logic              owner_valid;
  logic              cnt_free;
  logic              forward;
  logic              accept;
  logic              accept_read;
  logic [ADDR_W-1:0] held_addr;
  logic [DATA_W-1:0] held_data;

  assign mi_bus = i_MI_Bus;
  assign pr_bus = i_PR_Bus;
  assign fr_bus = {i_FR_Bus, {DATA_W{1'b0}}};

  always_comb begin
    owner_bus  = '0;
    owner_src  = SRC_MI;
    owner_live = 1'b0;
    case (state)
      ST_INIT: begin
        owner_bus  = mi_bus;
        owner_live = 1'b1;
      end
      ST_PR_OWN: begin
        owner_bus  = pr_bus;
        owner_src  = SRC_PR;
        owner_live = 1'b1;
      end
      ST_FR_OWN: begin
        owner_bus  = fr_bus;
        owner_src  = SRC_FR;
        owner_live = 1'b1;
      end
      default: ;
    endcase
  end

  assign owner_valid = cmd_is_active(owner_bus.cmd);
  assign forward     = owner_live && cnt_free && !i_Rst;
  assign accept      = forward && owner_valid;
  assign accept_read = (owner_bus.cmd == CMD_READ);

  // While the bus is busy the controller sees NOP with the last address/data.
  always_comb begin
    out_bus = '0;
    if (!i_Rst) begin
      if (forward) begin
        out_bus = owner_bus;
        if (!owner_valid) out_bus.cmd = CMD_NOP;
      end else begin
        out_bus.addr = held_addr;
        out_bus.data = held_data;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    to_fr_nxt = to_fr;
    case (state)
      ST_INIT: begin
        if (i_Init_Done && cnt_free && !accept) state_nxt = ST_PR_OWN;
      end
      ST_PR_OWN: begin
        if (i_FR_Request && cnt_free && !accept) begin
          state_nxt = ST_SWITCH;
          to_fr_nxt = 1'b1;
        end
      end
      ST_FR_OWN: begin
        if (!i_FR_Request && cnt_free && !accept) begin
          state_nxt = ST_SWITCH;
          to_fr_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = to_fr ? ST_FR_OWN : ST_PR_OWN;
      end
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state     <= ST_INIT;
      to_fr     <= 1'b0;
      held_addr <= '0;
      held_data <= '0;
    end else begin
      state     <= state_nxt;
      to_fr     <= to_fr_nxt;
      held_addr <= out_bus.addr;
      held_data <= out_bus.data;
    end
  end

  sdram_txn_tracker #(
    .READ_BURST_LENGTH (READ_BURST_LENGTH),
    .WRITE_BURST       (WRITE_BURST),
    .TIMEOUT_CYCLES    (TIMEOUT_CYCLES)
  ) u_tracker (
    .clk             (i_Clk),
    .rst             (i_Rst),
    .accept          (accept),
    .accept_read     (accept_read),
    .accept_src      (owner_src),
    .data_read_valid (i_Data_Read_Valid),
    .data_write_done (i_Data_Write_Done),
    .free            (cnt_free),
    .fr_read_valid   (o_FR_Read_Valid),
    .pr_read_valid   (o_PR_Read_Valid),
    .mi_write_done   (o_MI_Write_Done),
    .pr_write_done   (o_PR_Write_Done),
    .timeout         (o_Timeout)
  );

  assign o_Bus        = out_bus;
  assign o_Cmd_Accept = accept;
  assign o_PR_Grant   = !i_Rst && (state == ST_PR_OWN);
  assign o_FR_Grant   = !i_Rst && (state == ST_FR_OWN);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a per-cycle vector table followed by
// reset-mid-burst and timeout sequences.
module tb_sdram_arbiter;

  logic        i_Clk = 1'b0;
  logic        i_Rst = 1'b1;
  logic        i_Init_Done = 1'b0;
  logic        i_FR_Request = 1'b0;
  logic        i_Data_Read_Valid = 1'b0;
  logic        i_Data_Write_Done = 1'b0;
  logic [55:0] i_MI_Bus = '0;
  logic [55:0] i_PR_Bus = '0;
  logic [23:0] i_FR_Bus = '0;
  logic [55:0] o_Bus;
  logic        o_FR_Grant, o_PR_Grant, o_Cmd_Accept;
  logic        o_FR_Read_Valid, o_PR_Read_Valid, o_MI_Write_Done, o_PR_Write_Done, o_Timeout;

  sdram_arbiter dut (
    .i_Clk             (i_Clk),
    .i_Rst             (i_Rst),
    .i_Init_Done       (i_Init_Done),
    .i_MI_Bus          (i_MI_Bus),
    .i_FR_Request      (i_FR_Request),
    .i_FR_Bus          (i_FR_Bus),
    .i_PR_Bus          (i_PR_Bus),
    .i_Data_Read_Valid (i_Data_Read_Valid),
    .i_Data_Write_Done (i_Data_Write_Done),
    .o_Bus             (o_Bus),
    .o_FR_Grant        (o_FR_Grant),
    .o_PR_Grant        (o_PR_Grant),
    .o_Cmd_Accept      (o_Cmd_Accept),
    .o_FR_Read_Valid   (o_FR_Read_Valid),
    .o_PR_Read_Valid   (o_PR_Read_Valid),
    .o_MI_Write_Done   (o_MI_Write_Done),
    .o_PR_Write_Done   (o_PR_Write_Done),
    .o_Timeout         (o_Timeout)
  );

  always #5 i_Clk = ~i_Clk;

  // input flags {rst, init_done, fr_request, read_valid, write_done}
  localparam logic [4:0] RST = 5'b10000;
  localparam logic [4:0] IDN = 5'b01000;
  localparam logic [4:0] FRQ = 5'b00100;
  localparam logic [4:0] RV  = 5'b00010;
  localparam logic [4:0] WD  = 5'b00001;
  localparam logic [4:0] NONE = 5'b00000;

  // expected flags {pr_grant, fr_grant, accept, fr_rv, pr_rv, mi_wd, pr_wd, timeout}
  localparam logic [7:0] PG  = 8'h80;
  localparam logic [7:0] FG  = 8'h40;
  localparam logic [7:0] ACC = 8'h20;
  localparam logic [7:0] FRV = 8'h10;
  localparam logic [7:0] PRV = 8'h08;
  localparam logic [7:0] MWD = 8'h04;
  localparam logic [7:0] PWD = 8'h02;
  localparam logic [7:0] NOF = 8'h00;

  localparam logic [1:0] C_NOP = 2'd0;
  localparam logic [1:0] C_RD  = 2'd1;
  localparam logic [1:0] C_WR  = 2'd2;

  localparam logic [55:0] MW       = {2'd2, 22'h000010, 32'hDEADBEEF};
  localparam logic [55:0] MI_ZERO  = 56'h0;
  localparam logic [55:0] MI_NOP12 = {2'd0, 22'h000012, 32'h0};
  localparam logic [55:0] PR_RD    = {2'd1, 22'h0000A0, 32'h0};
  localparam logic [55:0] PR_IDLE  = {2'd0, 22'h000055, 32'h00001234};
  localparam logic [55:0] PR_C3    = {2'd3, 22'h0001AB, 32'h0};
  localparam logic [55:0] PR_WR    = {2'd2, 22'h0002C0, 32'h0000CAFE};
  localparam logic [55:0] PR_RD2   = {2'd1, 22'h0002C4, 32'h0};
  localparam logic [55:0] PR_WR2   = {2'd2, 22'h0002C8, 32'h0};
  localparam logic [55:0] PR_WR3   = {2'd2, 22'h0003F0, 32'h00000BAD};
  localparam logic [23:0] FR_RD    = {2'd1, 22'h000300};
  localparam logic [23:0] FR_IDLE  = {2'd0, 22'h000077};

  typedef struct {
    string       name;
    logic [4:0]  in_f;
    logic [55:0] mi;
    logic [55:0] pr;
    logic [23:0] fr;
    logic [1:0]  exp_cmd;
    logic [21:0] exp_addr;
    logic [7:0]  exp_f;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void add(input string n, input logic [4:0] f, input logic [55:0] mi,
                              input logic [55:0] pr, input logic [23:0] fr, input logic [1:0] ec,
                              input logic [21:0] ea, input logic [7:0] ef);
    vec_t v;
    v.name = n; v.in_f = f; v.mi = mi; v.pr = pr; v.fr = fr;
    v.exp_cmd = ec; v.exp_addr = ea; v.exp_f = ef;
    vecs.push_back(v);
  endfunction

  task automatic cyc();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] f, input logic [55:0] mi, input logic [55:0] pr,
                       input logic [23:0] fr);
    {i_Rst, i_Init_Done, i_FR_Request, i_Data_Read_Valid, i_Data_Write_Done} = f;
    i_MI_Bus = mi;
    i_PR_Bus = pr;
    i_FR_Bus = fr;
  endtask

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", n, act, exp);
    end
  endtask

  task automatic chk_row(input string n, input logic [1:0] ec, input logic [21:0] ea,
                         input logic [7:0] ef);
    logic [7:0] f;
    f = {o_PR_Grant, o_FR_Grant, o_Cmd_Accept, o_FR_Read_Valid, o_PR_Read_Valid,
         o_MI_Write_Done, o_PR_Write_Done, o_Timeout};
    chk({n, " flags"}, 64'(f), 64'(ef));
    chk({n, " cmd"}, 64'(o_Bus[55:54]), 64'(ec));
    chk({n, " addr"}, 64'(o_Bus[53:32]), 64'(ea));
  endtask

  initial begin
    int  wait_n;
    logic seen;

    add("reset",      RST | IDN, MW,      PR_IDLE, FR_IDLE, C_NOP, 22'h0,   NOF);
    add("mi_wr_acc",  IDN,       MW,      PR_IDLE, FR_IDLE, C_WR,  22'h10,  ACC);
    add("mi_wd",      IDN | WD,  MI_ZERO, PR_IDLE, FR_IDLE, C_NOP, 22'h0,   MWD);
    add("pr_rd_acc",  NONE,      MI_ZERO, PR_RD,   FR_IDLE, C_RD,  22'hA0,  PG | ACC);
    add("pr_beat1",   FRQ | RV,  MI_ZERO, PR_IDLE, FR_IDLE, C_NOP, 22'hA0,  PG | PRV);
    add("pr_beat2",   FRQ | RV,  MI_ZERO, PR_IDLE, FR_IDLE, C_NOP, 22'hA0,  PG | PRV);
    add("pr_gap",     FRQ,       MI_ZERO, PR_IDLE, FR_IDLE, C_NOP, 22'hA0,  PG);
    for (int b = 3; b <= 7; b++)
      add("pr_beat",  FRQ | RV,  MI_ZERO, PR_IDLE, FR_IDLE, C_NOP, 22'hA0,  PG | PRV);
    add("pr_beat8",   FRQ | RV,  MI_ZERO, PR_IDLE, FR_IDLE, C_NOP, 22'h55,  PG | PRV);
    add("switch_fr",  FRQ,       MI_ZERO, PR_RD,   FR_RD,   C_NOP, 22'h55,  NOF);
    add("fr_rd_acc",  FRQ,       MI_ZERO, PR_RD,   FR_RD,   C_RD,  22'h300, FG | ACC);
    for (int b = 1; b <= 7; b++)
      add("fr_beat",  RV,        MI_ZERO, PR_RD,   FR_IDLE, C_NOP, 22'h300, FG | FRV);
    add("fr_beat8",   RV,        MI_ZERO, PR_RD,   FR_IDLE, C_NOP, 22'h77,  FG | FRV);
    add("switch_pr",  NONE,      MI_ZERO, PR_RD,   FR_IDLE, C_NOP, 22'h77,  NOF);
    add("pr_code3",   NONE,      MI_ZERO, PR_C3,   FR_IDLE, C_NOP, 22'h1AB, PG);
    add("stray_idle", RV | WD,   MI_ZERO, PR_IDLE, FR_IDLE, C_NOP, 22'h55,  PG);
    add("pr_wr_acc",  NONE,      MI_ZERO, PR_WR,   FR_IDLE, C_WR,  22'h2C0, PG | ACC);
    add("wd_and_acc", WD,        MI_ZERO, PR_RD2,  FR_IDLE, C_RD,  22'h2C4, PG | ACC | PWD);
    add("busy_hold",  RV | WD,   MI_ZERO, PR_WR2,  FR_IDLE, C_NOP, 22'h2C4, PG | PRV);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc();
      drive(vecs[i].in_f, vecs[i].mi, vecs[i].pr, vecs[i].fr);
      #2;
      chk_row(vecs[i].name, vecs[i].exp_cmd, vecs[i].exp_addr, vecs[i].exp_f);
    end

    // busy_hold delivered beat 1 of the 0x2C4 read; two more make three.
    for (int i = 0; i < 2; i++) begin
      cyc();
      drive(RV, MI_ZERO, PR_IDLE, FR_IDLE);
      #2;
      chk_row("pre_rst_beat", C_NOP, 22'h2C4, PG | PRV);
    end

    cyc();
    drive(RST | RV, MW, PR_WR, FR_RD);
    #2;
    chk_row("mid_rst", C_NOP, 22'h0, NOF);
    chk("mid_rst data", 64'(o_Bus[31:0]), 64'h0);

    for (int i = 0; i < 5; i++) begin
      cyc();
      drive(RV, MI_NOP12, PR_IDLE, FR_IDLE);
      #2;
      chk_row("stray_after_rst", C_NOP, 22'h12, NOF);
    end

    cyc();
    drive(IDN, MI_NOP12, PR_IDLE, FR_IDLE);
    #2;
    chk_row("init_leave", C_NOP, 22'h12, NOF);

    cyc();
    drive(NONE, MI_ZERO, PR_WR3, FR_IDLE);
    #2;
    chk_row("to_wr_acc", C_WR, 22'h3F0, PG | ACC);

    wait_n = 0;
    seen   = 1'b0;
    while (!seen && wait_n < 1100) begin
      cyc();
      drive(NONE, MI_ZERO, PR_IDLE, FR_IDLE);
      #2;
      wait_n++;
      if (o_Timeout) seen = 1'b1;
    end
    chk("timeout_seen", 64'(seen), 64'h1);
    chk("timeout_latency", 64'(wait_n), 64'd1024);

    cyc();
    drive(NONE, MI_ZERO, PR_RD, FR_IDLE);
    #2;
    chk_row("post_timeout_acc", C_RD, 22'hA0, PG | ACC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
